usb_phy_io: RTL

- Parametrised pad-side front end between usb_dfu_core and the USB D+/D- pads. Successor to the fixed combinational tristate and receive-mux wrapper.
- Adds a registered transmit path, an input synchroniser, and a glitch-filtered line-state decoder.
- Adds bus-turnaround receive masking and bus-reset detection.
- Adds a soft-detach FSM that drives the D+ pull-up, so DFU manifest can force host re-enumeration.
- Pads are exposed as separate o/oe/i signals; the top level binds them to bidirectional buffers.

---
 rtl/usb_phy_io.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_phy_io.sv
// Pad-side USB front end: registered TX drive, RX synchroniser with turnaround masking,
// glitch-filtered line-state decoder, bus-reset detector and soft-detach pull-up control.
module usb_phy_io #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_LEN    = 3,
    parameter int TURNAROUND    = 2,
    parameter int DETACH_CYCLES = 480000,
    parameter int RESET_CYCLES  = 120,
    parameter int CNT_W         = 20
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic       usb_p_tx,
    input  logic       usb_n_tx,
    input  logic       usb_tx_en,
    output logic       usb_p_rx,
    output logic       usb_n_rx,
    output logic       pad_p_o,
    output logic       pad_n_o,
    output logic       pad_oe,
    input  logic       pad_p_i,
    input  logic       pad_n_i,
    output logic       pullup_en,
    input  logic       detach_req,
    output logic       attached,
    output logic [1:0] line_state,
    output logic       usb_reset_det
);

    localparam int HW = $clog2(TURNAROUND + 2);
    localparam int FW = $clog2(FILTER_LEN + 2);
    localparam int RW = $clog2(RESET_CYCLES + 2);

    localparam logic [CNT_W-1:0] DETACH_LOAD = CNT_W'(DETACH_CYCLES);
    localparam logic [HW-1:0]    TA_LOAD     = HW'(TURNAROUND);
    localparam logic [FW-1:0]    FILT_MAX    = FW'(FILTER_LEN);
    localparam logic [RW-1:0]    SE0_MAX     = RW'(RESET_CYCLES);

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;

    typedef enum logic {
        ST_DETACH   = 1'b0,
        ST_ATTACHED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] det_cnt_q, det_cnt_d;

    logic                   pad_oe_d;
    logic [SYNC_STAGES-1:0] sync_p_q, sync_n_q;
    logic                   sync_p, sync_n;
    logic [HW-1:0]          ta_q, ta_d;
    logic                   rx_block;
    logic [1:0]             raw_state, prev_raw_q;
    logic [FW-1:0]          stab_q, stab_d;
    logic [RW-1:0]          se0_cnt_q;

    // ---------------- detach FSM ----------------
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_DETACH;
            det_cnt_q <= DETACH_LOAD;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            det_cnt_q <= det_cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns state_d/det_cnt_d and no latch is inferred.
        state_d   = state_q;
        det_cnt_d = det_cnt_q;
        case (state_q)
            ST_DETACH: begin
                // A request landing on the terminal count still restarts the hold.
                if (detach_req)
                    det_cnt_d = DETACH_LOAD;
                else if (det_cnt_q == '0)
                    state_d = ST_ATTACHED;
                else
                    det_cnt_d = det_cnt_q - CNT_W'(1);
            end
            ST_ATTACHED: begin
                if (detach_req) begin
                    state_d   = ST_DETACH;
                    det_cnt_d = DETACH_LOAD;
                end
            end
            default: begin
                state_d   = ST_DETACH;
                det_cnt_d = DETACH_LOAD;
            end
        endcase
    end

    assign pullup_en = (state_q == ST_ATTACHED);
    assign attached  = (state_q == ST_ATTACHED);

    // ---------------- TX path ----------------
    // Gate on the next state so a detach request drops the drive in the same edge the FSM leaves.
    assign pad_oe_d = usb_tx_en && (state_d == ST_ATTACHED);

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            pad_oe  <= 1'b0;
            pad_p_o <= 1'b1;
            pad_n_o <= 1'b0;
        end else begin
            pad_oe  <= pad_oe_d;
            pad_p_o <= usb_p_tx;
            pad_n_o <= usb_n_tx;
        end
    end

    // ---------------- RX synchroniser ----------------
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: synchroniser flops reset to idle J so the filter sees a stable line out of reset.
            sync_p_q <= '1;
            sync_n_q <= '0;
        end else begin
            sync_p_q <= {sync_p_q[SYNC_STAGES-2:0], pad_p_i};
            sync_n_q <= {sync_n_q[SYNC_STAGES-2:0], pad_n_i};
        end
    end

    assign sync_p = sync_p_q[SYNC_STAGES-1];
    assign sync_n = sync_n_q[SYNC_STAGES-1];

    // ---------------- turnaround holdoff ----------------
    always_comb begin
        ta_d = ta_q;
        if (pad_oe && !pad_oe_d)
            ta_d = TA_LOAD;
        else if (pad_oe_d)
            ta_d = '0;
        else if (ta_q != '0)
            ta_d = ta_q - HW'(1);
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n)
            ta_q <= '0;
        else
            ta_q <= ta_d;
    end

    // Our own transmission echoes on the pads; hide it and the line settling afterwards.
    assign rx_block = pad_oe || (ta_q != '0);

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            usb_p_rx <= 1'b1;
            usb_n_rx <= 1'b0;
        end else if (rx_block) begin
            usb_p_rx <= 1'b1;
            usb_n_rx <= 1'b0;
        end else begin
            usb_p_rx <= sync_p;
            usb_n_rx <= sync_n;
        end
    end

    // ---------------- line-state filter ----------------
    assign raw_state = {sync_n, sync_p};

    always_comb begin
        if (raw_state != prev_raw_q)
            stab_d = FW'(1);
        else if (stab_q == FILT_MAX)
            stab_d = stab_q;
        else
            stab_d = stab_q + FW'(1);
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            prev_raw_q <= LS_J;
            stab_q     <= FILT_MAX;
            line_state <= LS_J;
        end else if (!rx_block) begin
            // History is frozen with the counter so a blocked window cannot count as stable time.
            prev_raw_q <= raw_state;
            stab_q     <= stab_d;
            if (stab_d == FILT_MAX)
                line_state <= raw_state;
        end
    end

    // ---------------- bus reset detection ----------------
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n)
            se0_cnt_q <= '0;
        else if ((line_state == LS_SE0) && (state_q == ST_ATTACHED)) begin
            if (se0_cnt_q != SE0_MAX)
                se0_cnt_q <= se0_cnt_q + RW'(1);
        end else
            se0_cnt_q <= '0;
    end

    assign usb_reset_det = (se0_cnt_q >= SE0_MAX);

endmodule
